// File: rtl/clk_period_monitor_if.sv
// Signal bundle between a slow divided clock source and its period monitor.
//   sig_in      : slow divided clock being monitored (source -> monitor)
//   half_period : last measured edge-to-edge interval in clk_in cycles
//   meas_valid  : one-cycle pulse when half_period updates
//   timeout     : level, slow clock has stopped toggling
//   locked      : level, slow clock period is within tolerance
// master = slow clock source / observer, slave = the monitor.
interface clk_period_monitor_if #(
    parameter int CNT_WIDTH = 38
);
    logic                 sig_in;
    logic [CNT_WIDTH-1:0] half_period;
    logic                 meas_valid;
    logic                 timeout;
    logic                 locked;

    modport master (
        output sig_in,
        input  half_period, meas_valid, timeout, locked
    );

    modport slave (
        input  sig_in,
        output half_period, meas_valid, timeout, locked
    );
endinterface

// File: rtl/clk_period_monitor.sv
// Measures the half-period of a slow divided clock in clk_in cycles, flags a
// stopped clock and reports lock once several consecutive measurements fall
// within tolerance of the nominal half-period.
//   clk_in : system clock, all logic on its rising edge
//   rst    : synchronous active-high reset
//   bus    : slave side of clk_period_monitor_if (sig_in in, results out)
module clk_period_monitor #(
    parameter int CNT_WIDTH  = 38,
    parameter int EXPECTED   = 200001,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 400002
) (
    input  logic                  clk_in,
    input  logic                  rst,
    clk_period_monitor_if.slave   bus
);
    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH:0]   EXP_V   = (CNT_WIDTH + 1)'(EXPECTED);
    localparam logic [CNT_WIDTH:0]   TOL_V   = (CNT_WIDTH + 1)'(TOL);
    localparam logic [MC_W-1:0]      LOCK_V  = MC_W'(LOCK_COUNT);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t               state;
    logic                 s1, s2, s3;
    logic [CNT_WIDTH-1:0] cnt;
    logic [MC_W-1:0]      match_cnt;
    logic [CNT_WIDTH-1:0] half_period;
    logic                 meas_valid;
    logic                 timeout;
    logic                 locked;

    logic                 edge_det;
    logic [CNT_WIDTH:0]   meas;
    logic [CNT_WIDTH:0]   dev;
    logic                 match;
    logic [MC_W-1:0]      match_next;

    // s1/s2 form the synchronizer; s3 is the delayed copy for edge detect.
    assign edge_det = s2 ^ s3;

    // One extra bit so cnt+1 never wraps; deviation is taken from whichever
    // operand is larger so the subtraction cannot underflow.
    assign meas       = {1'b0, cnt} + (CNT_WIDTH + 1)'(1);
    assign dev        = (meas >= EXP_V) ? (meas - EXP_V) : (EXP_V - meas);
    assign match      = (dev <= TOL_V);
    assign match_next = (match_cnt == LOCK_V) ? match_cnt : match_cnt + MC_W'(1);

    assign bus.half_period = half_period;
    assign bus.meas_valid  = meas_valid;
    assign bus.timeout     = timeout;
    assign bus.locked      = locked;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= IDLE;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            cnt         <= '0;
            match_cnt   <= '0;
            half_period <= '0;
            meas_valid  <= 1'b0;
            timeout     <= 1'b0;
            locked      <= 1'b0;
        end else begin
            s1         <= bus.sig_in;
            s2         <= s1;
            s3         <= s2;
            meas_valid <= 1'b0;

            // Saturating counter: parks at TIMEOUT-1 while the clock is dead.
            if (edge_det)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_WIDTH'(1);

            case (state)
                IDLE: begin
                    if (edge_det) begin
                        state   <= MEASURE;
                        timeout <= 1'b0;
                    end
                end
                MEASURE: begin
                    // Edge is checked first so an edge landing on the
                    // timeout cycle is still a normal measurement.
                    if (edge_det) begin
                        half_period <= meas[CNT_WIDTH-1:0];
                        meas_valid  <= 1'b1;
                        if (match) begin
                            match_cnt <= match_next;
                            locked    <= (match_next == LOCK_V);
                        end else begin
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end
                    end else if (cnt == CNT_MAX) begin
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_period_monitor.sv
module tb_clk_period_monitor;
    localparam int CW  = 8;
    localparam int EXP = 10;
    localparam int TL  = 1;
    localparam int LC  = 3;
    localparam int TO  = 30;

    typedef struct {
        int             cyc;
        logic [CW-1:0]  hp;
        logic           lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t sb[$];

    // reference model state, driven purely from toggle timing
    bit   m_meas = 1'b0;
    int   m_mc   = 0;
    bit   m_lk   = 1'b0;
    int   last   = 0;

    clk_period_monitor_if #(.CNT_WIDTH(CW)) bus ();

    clk_period_monitor #(
        .CNT_WIDTH(CW), .EXPECTED(EXP), .TOL(TL),
        .LOCK_COUNT(LC), .TIMEOUT(TO)
    ) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0d exp %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every meas_valid must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.meas_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("valid_cyc", cyc, e.cyc);
                chk("half_period", bus.half_period, e.hp);
                chk("locked", bus.locked, e.lk);
            end
        end
    end

    // Wait n falling edges, flip sig_in, update model, push expected result.
    task automatic tog(input int n);
        int gap;
        repeat (n) @(negedge clk);
        bus.sig_in = ~bus.sig_in;
        gap  = cyc - last;
        last = cyc;
        if (!m_meas || gap > TO) begin
            if (m_meas) begin
                m_mc = 0;
                m_lk = 1'b0;
            end
            m_meas = 1'b1;
        end else begin
            if (gap >= EXP - TL && gap <= EXP + TL) begin
                if (m_mc < LC) m_mc++;
                m_lk = (m_mc == LC);
            end else begin
                m_mc = 0;
                m_lk = 1'b0;
            end
            sb.push_back('{cyc + 3, gap[CW-1:0], m_lk});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hp"}, bus.half_period, 0);
        chk({tag, "_to"}, bus.timeout, 0);
        chk({tag, "_lk"}, bus.locked, 0);
        chk({tag, "_mv"}, bus.meas_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst_hold");
        rst = 1'b0;
        m_meas = 1'b0;
        m_mc   = 0;
        m_lk   = 1'b0;
        last   = cyc;
        @(negedge clk);
        chk_zero("rst_rel");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.sig_in = 1'b0;
        // reset with sig_in toggling underneath; ends low so no edge on release
        repeat (4) begin
            @(negedge clk);
            bus.sig_in = ~bus.sig_in;
        end
        chk_zero("rst_init");
        rst = 1'b0;
        last = cyc;
        @(negedge clk);
        chk_zero("rst_after");

        // steady lock-in, then tolerance boundaries
        tog(5);
        tog(10); tog(10); tog(10);
        tog(9);  tog(11);
        tog(12);
        tog(10); tog(10); tog(10);
        tog(8);
        tog(10); tog(10); tog(10);
        repeat (4) @(negedge clk);
        chk("locked_level", bus.locked, 1);

        // stop toggling: timeout 30 cycles after the last detected edge
        repeat (28) @(negedge clk);
        chk("to_early", bus.timeout, 0);
        @(negedge clk);
        chk("to_set", bus.timeout, 1);
        chk("to_lk", bus.locked, 0);
        chk("to_hp_hold", bus.half_period, 10);
        tog(5);
        repeat (2) @(negedge clk);
        chk("to_still", bus.timeout, 1);
        @(negedge clk);
        chk("to_clear", bus.timeout, 0);
        tog(10);

        // reset in the middle of a measurement
        tog(10);
        repeat (8) @(negedge clk);
        do_reset();
        tog(7);
        tog(10);

        // edge coincident with the timeout cycle
        tog(30);
        repeat (3) @(negedge clk);
        chk("coinc_to", bus.timeout, 0);
        @(negedge clk);
        chk("coinc_to2", bus.timeout, 0);
        tog(10);

        repeat (6) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/clk_period_monitor.md
Name: clk_period_monitor

Overview:
- Receive-side counterpart of the lock's clock divider: measures the half-period of a slow divided clock in `clk_in` cycles.
- Flags when the slow clock stops toggling (timeout).
- Asserts `locked` once consecutive measurements sit within tolerance of the expected half-period.
- Sits beside the divider; gates keypad/lock FSM activity on a healthy slow clock.

Parameters:
- CNT_WIDTH, 38, width of the cycle counter and of `half_period`.
- EXPECTED, 200001, nominal half-period in `clk_in` cycles (divider toggle value + 1).
- TOL, 2, allowed absolute deviation from EXPECTED, inclusive.
- LOCK_COUNT, 4, consecutive in-tolerance measurements required to assert `locked`; must be ≥ 1.
- TIMEOUT, 400002, cycles without an edge before timeout; must be > EXPECTED + TOL.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  slow divided clock to monitor; asynchronous to `clk_in`.
- half_period  output  CNT_WIDTH  last measured edge-to-edge interval, in `clk_in` cycles.
- meas_valid  output  1  one-cycle pulse when `half_period` updates.
- timeout  output  1  level; high from timeout detection until the next detected edge.
- locked  output  1  level; slow clock is within tolerance.

Behaviour:
- Reset: all outputs, counters, synchronizer flops and match count are 0; state is IDLE. `rst` has priority over all other events, including mid-measurement.
- Synchronizer and edge detect:
  - s1<=sig_in, s2<=s1, s3<=s2; edge = s2 ^ s3.
  - Both rising and falling edges count.
  - A `sig_in` change at cycle k is detected at cycle k+2.
  - Registered outputs update at cycle k+3.
- Counter:
  - On edge, cnt <= 0; otherwise cnt <= cnt+1.
  - Measured value = cnt+1, i.e. the number of `clk_in` cycles between consecutive detected edges.
  - Edges N cycles apart yield half_period = N.
  - cnt saturates at TIMEOUT-1 and never wraps.
- States: IDLE, MEASURE.
  - IDLE: no reference edge yet. On edge: go to MEASURE, cnt <= 0, timeout <= 0, no `meas_valid`.
  - MEASURE, on edge: half_period <= cnt+1, meas_valid <= 1 for one cycle, cnt <= 0, stay in MEASURE.
  - MEASURE, when cnt == TIMEOUT-1 with no edge: timeout <= 1, locked <= 0, match count <= 0, go to IDLE. `half_period` holds its last value.
  - Edge and timeout in the same cycle: the edge wins; it is treated as a normal measurement.
- Lock logic (evaluated on each measurement, registered together with `meas_valid`):
  - match = |(cnt+1) − EXPECTED| ≤ TOL; compute without unsigned underflow.
  - On match: match count <= min(count+1, LOCK_COUNT); locked <= 1 when the new count == LOCK_COUNT.
  - On mismatch: match count <= 0; locked <= 0 in the same cycle `meas_valid` pulses.
  - `locked` changes only on a measurement, a timeout, or reset.
- `meas_valid` is never asserted in IDLE, or in two consecutive cycles except for back-to-back edges. Two-cycle edge spacing gives half_period=2; spacing of 1 is outside the spec.

Test Plan (bench params: CNT_WIDTH=8, EXPECTED=10, TOL=1, LOCK_COUNT=3, TIMEOUT=30):
- Reset: hold `rst` 3 cycles with `sig_in` toggling -> all outputs 0, no `meas_valid` during or in the first cycle after release.
- Steady toggle every 10 cycles:
  - First edge -> no pulse.
  - Second edge -> `meas_valid` exactly 3 cycles after the `sig_in` change, half_period=10.
  - `locked`=1 together with the third valid.
- Tolerance edges: intervals 9, 11 -> match count advances. Interval 8 or 12 -> `locked` and match count clear on that `meas_valid`.
- Stop toggling after lock -> `timeout`=1 exactly 30 cycles after the last detected edge, `locked`=0, `half_period` holds 10. Next edge -> `timeout`=0, no pulse. Following edge resumes measurement.
- Reset mid-measure: assert `rst` 5 cycles after an edge in MEASURE -> outputs 0. Next edge produces no `meas_valid` (IDLE).
- Edge coincident with the timeout cycle (interval 30) -> `meas_valid` with half_period=30, `timeout` stays 0, state MEASURE.
